decoder_scan_ctrl: RTL

Upstream sequencer for the 4-to-16 gate-level binary decoder. It drives the decoder's 4-bit address `a` and enable `en`, stepping through a programmable channel range. Each channel gets a fixed blanking gap followed by a programmable dwell time. Typical uses are LED/row scanning and one-hot channel strobing on the prototyping board.

---
 rtl/decoder_scan_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 4-to-16 decoder: steps address a over a latched channel
// range, inserting a fixed blanking gap before each programmable dwell window.
module decoder_scan_ctrl #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [3:0]         first,
  input  logic [3:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         a,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BLANK  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]   BLANK_LOAD = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [DWELL_W-1:0] DWELL_ZERO = DWELL_W'(32'd0);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(32'd1);

  logic [1:0]         state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [3:0]         first_r, first_s;
  logic [3:0]         last_r, last_s;
  logic               mode_r, mode_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [3:0]         a_r, a_s;
  logic               en_r, en_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               wrap_r, wrap_s;
  logic [DWELL_W-1:0] dwell_eff_s;

  // Next-state, counter and output decode for the scan sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    first_s     = first_r;
    last_s      = last_r;
    mode_s      = mode_r;
    dwell_s     = dwell_r;
    a_s         = a_r;
    en_s        = en_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    wrap_s      = 1'b0;
    dwell_eff_s = (dwell == DWELL_ZERO) ? DWELL_ONE : dwell;

    case (state_r)
      IDLE: begin
        en_s   = 1'b0;
        busy_s = 1'b0;
        if (start && !stop) begin
          first_s = first;
          last_s  = last;
          mode_s  = mode;
          dwell_s = dwell_eff_s;
          a_s     = first;
          busy_s  = 1'b1;
          if (BLANK_CYC == 0) begin
            state_s = ACTIVE;
            en_s    = 1'b1;
            cnt_s   = CNT_W'(dwell_eff_s - DWELL_ONE);
          end else begin
            state_s = BLANK;
            cnt_s   = BLANK_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BLANK: begin
        en_s = 1'b0;
        if (cnt_r == CNT_ZERO) begin
          state_s = ACTIVE;
          en_s    = 1'b1;
          cnt_s   = CNT_W'(dwell_r - DWELL_ONE);
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if ((a_r == last_r) && mode_r) begin
          state_s = IDLE;
          en_s    = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          // Advance (or return to first) and re-enter the blanking gap.
          if (a_r == last_r) begin
            a_s    = first_r;
            wrap_s = 1'b1;
          end else begin
            a_s = a_r + 4'd1;
          end
          if (BLANK_CYC == 0) begin
            state_s = ACTIVE;
            en_s    = 1'b1;
            cnt_s   = CNT_W'(dwell_r - DWELL_ONE);
          end else begin
            state_s = BLANK;
            en_s    = 1'b0;
            cnt_s   = BLANK_LOAD;
          end
        end
      end
      default: begin
        state_s = IDLE;
        en_s    = 1'b0;
        busy_s  = 1'b0;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // Abort overrides everything, including a pending done or wrap pulse.
    if (stop && (state_r != IDLE)) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
      a_s     = a_r;
      en_s    = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      wrap_s  = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, latched scan parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      first_r <= 4'd0;
      last_r  <= 4'd0;
      mode_r  <= 1'b0;
      dwell_r <= DWELL_ZERO;
      a_r     <= 4'd0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
      last_r  <= last_s;
      mode_r  <= mode_s;
      dwell_r <= dwell_s;
      a_r     <= a_s;
      en_r    <= en_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      wrap_r  <= wrap_s;
    end
  end

  assign a    = a_r;
  assign en   = en_r;
  assign busy = busy_r;
  assign done = done_r;
  assign wrap = wrap_r;

endmodule
